// File: rtl/home_auto_pkg.sv
// home_auto_pkg: shared constants and width helpers for the home automation blocks
// Provides the IDLE state code, a constant-foldable clog2 and the display width helper.
package home_auto_pkg;
  localparam int IDLE_CODE = 0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // State codes run 0..N+2 (IDLE plus N sensors, heater, cooler).
  function automatic int disp_w(input int n);
    return clog2(n + 3);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker over W request lines
// Ports: req (request lines), start (first index scanned), grant (chosen index), valid (any request).
// Scans start, start+1, ... wrapping modulo W; the lowest rotated position wins.
module rr_pick #(
  parameter int W = 6,
  parameter int IW = 3
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] grant,
  output logic          valid
);
  localparam logic [IW:0] WL = (IW+1)'(W);
  logic [2*W-1:0] dbl;
  logic [W-1:0] rot;
  logic [IW-1:0] pos;
  logic [IW:0] sum;
  assign dbl = {req, req} >> start;
  assign rot = dbl[W-1:0];
  always_comb begin
    pos = '0;
    valid = 1'b0;
    for (int k = W - 1; k >= 0; k--)
      if (rot[k]) begin
        pos = IW'(k);
        valid = 1'b1;
      end
    sum = {1'b0, start} + {1'b0, pos};
    grant = sum >= WL ? IW'(sum - WL) : sum[IW-1:0];
  end
endmodule

// File: rtl/home_event_scheduler.sv
// home_event_scheduler: round-robin scheduler over sensor, heater and cooler channels with dwell
// Ports: clk, rst (async active-high), sensors (level requests), temp (unsigned temperature),
//        ack (clears sticky latches), output_signals (one-hot drive), display (state code).
module home_event_scheduler
  import home_auto_pkg::*;
#(
  parameter int N_SENSORS = 4,
  parameter int TEMP_W = 6,
  parameter int HEAT_TH = 16,
  parameter int COOL_TH = 32,
  parameter int DWELL = 1,
  parameter logic [N_SENSORS-1:0] STICKY_MASK = N_SENSORS'(4'b0100)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_SENSORS-1:0]         sensors,
  input  logic [TEMP_W-1:0]            temp,
  input  logic                         ack,
  output logic [N_SENSORS+1:0]         output_signals,
  output logic [disp_w(N_SENSORS)-1:0] display
);
  localparam int NC = N_SENSORS + 2;
  localparam int DW = disp_w(N_SENSORS);
  localparam int CW = clog2(DWELL + 1);
  localparam logic [TEMP_W-1:0] HT = TEMP_W'(HEAT_TH);
  localparam logic [TEMP_W-1:0] CT = TEMP_W'(COOL_TH);
  localparam logic [DW-1:0] IDLE = DW'(IDLE_CODE);
  localparam logic [DW-1:0] NCL = DW'(NC);
  localparam logic [CW-1:0] DLOAD = CW'(DWELL - 1);
  if (HEAT_TH > COOL_TH) begin : g_bad_th
    $error("HEAT_TH must not exceed COOL_TH");
  end
  if (N_SENSORS < 1 || N_SENSORS > 16) begin : g_bad_n
    $error("N_SENSORS must be 1..16");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("DWELL must be at least 1");
  end
  logic [DW-1:0] state, start, grant;
  logic [CW-1:0] dwell_cnt;
  logic [N_SENSORS-1:0] latched, set_lat;
  logic [NC-1:0] req;
  logic valid, eval, bad;
  assign req = {temp >= CT, temp < HT, sensors | latched};
  assign bad = state > NCL;
  assign eval = state == IDLE || dwell_cnt == '0;
  // State code k+1 means channel k, so the scan starting at channel k+1 is just the code itself.
  assign start = (state == IDLE || state == NCL) ? '0 : state;
  // Shifting past N_SENSORS yields zero, so heater/cooler grants never latch.
  assign set_lat = (eval && valid && !bad) ? STICKY_MASK & (N_SENSORS'(1) << grant) : '0;
  assign display = state;
  rr_pick #(.W(NC), .IW(DW)) u_pick (
    .req(req),
    .start(start),
    .grant(grant),
    .valid(valid)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      output_signals <= '0;
      dwell_cnt <= '0;
      latched <= '0;
    end else begin
      latched <= ack ? '0 : latched | set_lat;
      if (bad) begin
        state <= IDLE;
        output_signals <= '0;
        dwell_cnt <= '0;
      end else if (eval) begin
        state <= valid ? grant + 1'b1 : IDLE;
        output_signals <= valid ? NC'(1) << grant : '0;
        dwell_cnt <= valid ? DLOAD : '0;
      end else begin
        dwell_cnt <= dwell_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_home_event_scheduler.sv
// tb_home_event_scheduler: directed bench with a channel-level model for three scheduler configurations
module tb_home_event_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] s0, s1;
  logic [7:0] s2;
  logic [5:0] t0, t1, t2;
  logic a0, a1, a2;
  logic [5:0] o0, o1;
  logic [9:0] o2;
  logic [2:0] d0, d1;
  logic [3:0] d2;
  int pass_n = 0;
  int total_n = 0;
  int m_ch[3];
  int m_dw[3];
  logic [15:0] m_lat[3];
  localparam int MN[3] = '{4, 4, 8};
  localparam int MD[3] = '{1, 4, 1};
  localparam logic [15:0] STK = 16'h0004;
  localparam int TEMPS[6] = '{15, 16, 31, 32, 0, 63};
  localparam int TEMP_EXP[6] = '{5, 0, 0, 6, 5, 6};

  home_event_scheduler u0 (.clk(clk), .rst(rst), .sensors(s0), .temp(t0), .ack(a0),
                           .output_signals(o0), .display(d0));
  home_event_scheduler #(.DWELL(4)) u1 (.clk(clk), .rst(rst), .sensors(s1), .temp(t1), .ack(a1),
                                        .output_signals(o1), .display(d1));
  home_event_scheduler #(.N_SENSORS(8), .STICKY_MASK(8'h04)) u2 (.clk(clk), .rst(rst), .sensors(s2),
                                        .temp(t2), .ack(a2), .output_signals(o2), .display(d2));

  always #5 clk = ~clk;

  // First requesting channel after cur (cur itself last); from idle (-1) the scan starts at 0.
  function automatic int pick(input int cur, input int nc, input logic [17:0] r);
    for (int k = 1; k <= nc; k++) begin
      int c;
      c = cur < 0 ? k - 1 : (cur + k) % nc;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [17:0] mreq(input int n, input logic [15:0] s, input logic [15:0] lat, input int t);
    logic [17:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = s[i] | lat[i];
    r[n] = t < 16;
    r[n+1] = t >= 32;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int j = 0; j < 3; j++) begin
      if (rst) begin
        m_ch[j] <= -1;
        m_dw[j] <= 0;
        m_lat[j] <= '0;
      end else begin
        automatic logic [15:0] s = j == 0 ? 16'(s0) : j == 1 ? 16'(s1) : 16'(s2);
        automatic int t = j == 0 ? int'(t0) : j == 1 ? int'(t1) : int'(t2);
        automatic logic a = j == 0 ? a0 : j == 1 ? a1 : a2;
        automatic logic [15:0] lat = m_lat[j];
        automatic int nx = 0;
        if (m_ch[j] < 0 || m_dw[j] == 0) begin
          nx = pick(m_ch[j], MN[j] + 2, mreq(MN[j], s, lat, t));
          if (nx >= 0 && nx < MN[j] && STK[nx]) lat[nx] = 1'b1;
          m_ch[j] <= nx;
          m_dw[j] <= nx < 0 ? 0 : MD[j] - 1;
        end else begin
          m_dw[j] <= m_dw[j] - 1;
        end
        m_lat[j] <= a ? '0 : lat;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic compare_all();
    for (int j = 0; j < 3; j++) begin
      int ad, ao;
      ad = j == 0 ? int'(d0) : j == 1 ? int'(d1) : int'(d2);
      ao = j == 0 ? int'(o0) : j == 1 ? int'(o1) : int'(o2);
      chk($sformatf("model_display_u%0d", j), ad, m_ch[j] + 1);
      chk($sformatf("model_outputs_u%0d", j), ao, m_ch[j] < 0 ? 0 : 1 << m_ch[j]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    s0 = '0; s1 = '0; s2 = '0;
    t0 = 6'd20; t1 = 6'd20; t2 = 6'd20;
    a0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
    tick();
    tick();
    chk("reset_display", int'(d0), 0);
    chk("reset_outputs", int'(o1), 0);
    rst = 1'b0;
    s0 = 4'b0101;
    tick(); chk("alt_fd_display", int'(d0), 1); chk("alt_fd_outputs", int'(o0), 1);
    tick(); chk("alt_fa_display", int'(d0), 3); chk("alt_fa_outputs", int'(o0), 4);
    tick(); chk("alt_fd_again", int'(d0), 1);
    tick(); chk("alt_fa_again", int'(d0), 3);
    s0 = '0; a0 = 1'b1;
    tick(); chk("ack_edge_hold", int'(d0), 3);
    a0 = 1'b0;
    tick(); chk("ack_then_idle", int'(d0), 0);
    s0 = 4'b0100;
    tick(); chk("sticky_enter", int'(d0), 3);
    s0 = '0;
    tick();
    tick(); chk("sticky_hold", int'(d0), 3);
    a0 = 1'b1;
    tick(); chk("sticky_ack_edge", int'(d0), 3);
    a0 = 1'b0;
    tick(); chk("sticky_released", int'(d0), 0);
    t0 = 6'd10;
    tick(); chk("heat_display", int'(d0), 5); chk("heat_outputs", int'(o0), 16);
    t0 = 6'd40;
    tick(); chk("cool_display", int'(d0), 6); chk("cool_outputs", int'(o0), 32);
    t0 = 6'd20;
    tick(); chk("temp_idle", int'(d0), 0);
    for (int i = 0; i < 6; i++) begin
      t0 = 6'(TEMPS[i]);
      tick(); chk($sformatf("temp_edge_%0d", TEMPS[i]), int'(d0), TEMP_EXP[i]);
    end
    t0 = 6'd20;
    tick();
    s1 = 4'b0001;
    tick(); chk("dwell_fd_first", int'(d1), 1);
    s1 = 4'b0010;
    tick(); tick(); tick(); chk("dwell_fd_last", int'(d1), 1);
    tick(); chk("dwell_rd_display", int'(d1), 2); chk("dwell_rd_outputs", int'(o1), 2);
    tick(); tick(); chk("dwell_rd_mid", int'(d1), 2);
    #2 rst = 1'b1;
    #1 chk("async_rst_display", int'(d1), 0); chk("async_rst_outputs", int'(o1), 0);
    tick();
    rst = 1'b0;
    tick(); chk("post_rst_eval", int'(d1), 2);
    tick(); tick(); tick(); chk("post_rst_dwell", int'(d1), 2);
    s1 = '0;
    s2 = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("wide_rr_%0d", i), int'(d2), (i % 8) + 1);
      chk($sformatf("wide_no_hvac_%0d", i), int'(o2[9:8]), 0);
    end
    s2 = '0;
    for (int i = 0; i < 60; i++) begin
      s0 = 4'($urandom); s1 = 4'($urandom); s2 = 8'($urandom);
      t0 = 6'($urandom); t1 = 6'($urandom); t2 = 6'($urandom);
      a0 = $urandom_range(0, 3) == 0; a1 = $urandom_range(0, 3) == 0; a2 = $urandom_range(0, 3) == 0;
      tick();
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/home_event_scheduler.md
HOME_EVENT_SCHEDULER -- requirements
Module: home_event_scheduler

Interface
REQ-001 SHALL have parameter N_SENSORS, default 4: number of discrete sensor channels, legal range 1..16.
REQ-002 SHALL have parameter TEMP_W, default 6: temperature input width.
REQ-003 SHALL have parameter HEAT_TH, default 16: heater request when temp < HEAT_TH.
REQ-004 SHALL have parameter COOL_TH, default 32: cooler request when temp >= COOL_TH; HEAT_TH <= COOL_TH, with elaboration error otherwise.
REQ-005 SHALL have parameter DWELL, default 1: minimum cycles spent in any non-IDLE state, legal range >= 1.
REQ-006 SHALL have parameter STICKY_MASK, default 4'b0100, width N_SENSORS: sensor channels whose request latches until ack.
REQ-007 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port sensors, input, N_SENSORS: level requests, bit i is channel i.
REQ-010 SHALL have port temp, input, TEMP_W: unsigned temperature.
REQ-011 SHALL have port ack, input, 1: single-cycle pulse clearing all sticky latches.
REQ-012 SHALL have port output_signals, output, N_SENSORS+2: registered one-hot drive; bit i is sensor i, bit N is heater, bit N+1 is cooler.
REQ-013 SHALL have port display, output, DISP_W=clog2(N_SENSORS+3): registered state code.

Function
REQ-014 Channels SHALL be indexed 0..N-1 for sensors, N for HEAT and N+1 for COOL; states are IDLE plus one state per channel.
REQ-015 State code SHALL be: IDLE=0, channel k = k+1.
REQ-016 Request vector SHALL be: req[i] = sensors[i] | latched[i] for i<N; req[N] = (temp < HEAT_TH); req[N+1] = (temp >= COOL_TH).
REQ-017 Next-state selection SHALL be round-robin: first asserted req scanning from current channel+1 upward, wrapping modulo N+2, with the current channel itself examined last.
REQ-018 From IDLE, the scan SHALL start at channel 0.
REQ-019 With no req asserted, the next state SHALL be IDLE.
REQ-020 On entry to a non-IDLE state, dwell_cnt SHALL load DWELL-1; selection SHALL be evaluated only when dwell_cnt==0, and otherwise the state holds and dwell_cnt decrements.
REQ-021 A request dropping during dwell SHALL NOT shorten the dwell.
REQ-022 DWELL=1 SHALL give per-cycle re-evaluation with no added latency.
REQ-023 IDLE SHALL evaluate every cycle.
REQ-024 Re-selecting the current channel when dwell_cnt==0 SHALL reload dwell_cnt; it is a fresh dwell.
REQ-025 latched[i] SHALL set on the edge entering sensor state i when STICKY_MASK[i]=1.
REQ-026 ack=1 SHALL clear all latched bits at the edge; ack has priority over a simultaneous set.
REQ-027 output_signals and display SHALL update on the same edge as the state, with zero cycles of skew between them.
REQ-028 In IDLE, output_signals SHALL be all-zero; in any other state, exactly one bit is set.
REQ-029 An out-of-range state code SHALL return to IDLE on the next edge.
REQ-030 Temperature comparisons SHALL be unsigned at TEMP_W width; thresholds are truncated to TEMP_W.

Reset
REQ-031 While rst is high, asynchronously: state=IDLE, display=0, output_signals=0, dwell_cnt=0, latched=0.
REQ-032 After rst deassertion, the first evaluation SHALL occur on the next rising edge, as from IDLE.
REQ-033 Reset mid-dwell SHALL abort the dwell with no residual effect.

Structure
REQ-034 Shared package home_auto_pkg SHALL hold the IDLE code constant, a clog2 function and the state-code width helper.
REQ-035 Round-robin selection SHALL be a sub-module rr_pick: inputs req and start index; outputs grant index and valid; purely combinational.
REQ-036 Top level SHALL hold the state register, dwell counter, latches and output registers.

Verification
REQ-037 Defaults, temp=20, sensors=0101 from IDLE: states FD(1) -> FA(3) -> FD(1) alternating each cycle; output_signals 000001 / 000100.
REQ-038 Defaults, sensors=0000, temp=10: display=5, output_signals=010000; then temp=40: next edge display=6, output_signals=100000.
REQ-039 DWELL=4, sensors=0001 for one cycle then 0010: FD held 4 cycles, then RD (display=2) for 4 cycles.
REQ-040 Defaults, sensors[2] pulsed one cycle, temp=20: FA; then with sensors=0 the state remains FA; ack pulse -> IDLE on the following edge.
REQ-041 Asynchronous rst asserted mid-cycle during DWELL=4 dwell in RD: outputs go to 0 immediately, without waiting for clk.
REQ-042 N_SENSORS=8, all sensors high, temp=20: display cycles 1..8 and wraps to 1; heater and cooler are never selected.
